// File: rtl/sim_ram_mp_if.sv
// Bus bundle of the multi-port simulation RAM:
// one byte-strobed write port and NRD request/valid read ports.
interface sim_ram_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int NRD    = 2
);
    logic                  we_i;
    logic [ADDR_W-1:0]     waddr_i;
    logic [DATA_W-1:0]     wdata_i;
    logic [DATA_W/8-1:0]   wstrb_i;
    logic                  werr_o;
    logic [NRD-1:0]        rd_req_i;
    logic [NRD*ADDR_W-1:0] rd_addr_i;
    logic [NRD-1:0]        rd_rvalid_o;
    logic [NRD*DATA_W-1:0] rd_data_o;
    logic [NRD-1:0]        rd_err_o;

    modport master (
        output we_i, waddr_i, wdata_i, wstrb_i,
        output rd_req_i, rd_addr_i,
        input  werr_o, rd_rvalid_o, rd_data_o, rd_err_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, wstrb_i,
        input  rd_req_i, rd_addr_i,
        output werr_o, rd_rvalid_o, rd_data_o, rd_err_o
    );
endinterface

// File: rtl/sim_ram_mp.sv
// Multi-port simulation RAM: one strobed write port, NRD read ports
// with per-byte same-cycle forwarding and 1- or 2-cycle read latency.
module sim_ram_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4096,
    parameter int NRD    = 2,
    parameter int RD_LAT = 1
) (
    input logic         clk,
    input logic         rst,
    sim_ram_mp_if.slave bus
);
    localparam int NB  = DATA_W / 8;
    localparam int OFS = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);
    localparam int TOP = OFS + IW;

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("sim_ram_mp: RD_LAT must be 1 or 2");
    end
    if (DATA_W % 8 != 0) begin : g_bad_dw
        $error("sim_ram_mp: DATA_W must be a multiple of 8");
    end
    if ((1 << IW) != DEPTH) begin : g_bad_depth
        $error("sim_ram_mp: DEPTH must be a power of two");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IW-1:0]         widx;
    logic                  w_inr;
    logic                  w_ok;
    logic                  werr_q;
    logic [NRD-1:0]        rv;
    logic [NRD-1:0]        re;
    logic [NRD*DATA_W-1:0] rdat;
    logic                  unused_addr;

    assign widx  = bus.waddr_i[OFS +: IW];
    assign w_inr = bus.waddr_i[ADDR_W-1:TOP] == '0;
    assign w_ok  = bus.we_i && w_inr;

    // low byte-offset bits never select anything
    assign unused_addr = ^{bus.waddr_i, bus.rd_addr_i};

    always_ff @(posedge clk) begin
        if (!rst && w_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.wstrb_i[b]) begin
                    mem[widx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            werr_q <= 1'b0;
        end else begin
            werr_q <= bus.we_i && !w_inr;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic [IW-1:0]     idx;
        logic              inr;
        logic              req;
        logic [DATA_W-1:0] word;
        logic [DATA_W-1:0] fwd;
        logic              v1;
        logic              e1;
        logic [DATA_W-1:0] d1;

        assign addr = bus.rd_addr_i[p*ADDR_W +: ADDR_W];
        assign idx  = addr[OFS +: IW];
        assign inr  = addr[ADDR_W-1:TOP] == '0;
        assign req  = bus.rd_req_i[p];
        assign word = mem[idx];

        // pre-edge memory word overlaid with this edge's strobed bytes
        always_comb begin
            fwd = word;
            for (int b = 0; b < NB; b++) begin
                if (w_ok && widx == idx && bus.wstrb_i[b]) begin
                    fwd[8*b +: 8] = bus.wdata_i[8*b +: 8];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v1 <= 1'b0;
                e1 <= 1'b0;
                d1 <= '0;
            end else begin
                v1 <= req;
                e1 <= req && !inr;
                d1 <= (req && inr) ? fwd : '0;
            end
        end

        if (RD_LAT == 2) begin : g_lat2
            logic              v2;
            logic              e2;
            logic [DATA_W-1:0] d2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v2 <= 1'b0;
                    e2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    e2 <= e1;
                    d2 <= d1;
                end
            end

            assign rv[p]                   = v2;
            assign re[p]                   = e2;
            assign rdat[p*DATA_W +: DATA_W] = d2;
        end else begin : g_lat1
            assign rv[p]                   = v1;
            assign re[p]                   = e1;
            assign rdat[p*DATA_W +: DATA_W] = d1;
        end
    end

    assign bus.werr_o      = werr_q;
    assign bus.rd_rvalid_o = rv;
    assign bus.rd_err_o    = re;
    assign bus.rd_data_o   = rdat;
endmodule
